// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counter: FSM encoding and BCD digit limits.
package stopwatch_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t DIGIT_MAX    = 4'd9;
    localparam digit_t SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
    } state_e;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses, timer handshake and BCD display digits of the stopwatch counter.
interface stopwatch_counter_if;
    import stopwatch_pkg::*;

    logic   tick_10ms;
    logic   start_stop;
    logic   lap;
    logic   clear;
    logic   timer_enabled;
    logic   timer_clear;
    logic   running;
    logic   lap_active;
    logic   overflow;
    digit_t disp_min_tens;
    digit_t disp_min_ones;
    digit_t disp_sec_tens;
    digit_t disp_sec_ones;
    digit_t disp_hund_tens;
    digit_t disp_hund_ones;

    modport master (
        output tick_10ms, start_stop, lap, clear,
        input  timer_enabled, timer_clear, running, lap_active, overflow,
        input  disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
        input  disp_hund_tens, disp_hund_ones
    );

    modport slave (
        input  tick_10ms, start_stop, lap, clear,
        output timer_enabled, timer_clear, running, lap_active, overflow,
        output disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones,
        output disp_hund_tens, disp_hund_ones
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..Limit; carry is combinational so a whole cascade ripples in one cycle.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter digit_t Limit = DIGIT_MAX
) (
    input  logic   clk,
    input  logic   sync_reset,
    input  logic   inc,
    input  logic   clr,
    output digit_t value,
    output logic   carry
);

    digit_t value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = (value_q == Limit) ? '0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && (value_q == Limit);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: run/pause/idle FSM, MM:SS.hh BCD cascade, lap snapshot and display mux.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter bit          WRAP_AT_MAX  = 1'b1,
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input logic                clk,
    input logic                sync_reset,
    stopwatch_counter_if.slave bus
);

    localparam digit_t MinTensMax = digit_t'(MAX_MIN_TENS);

    // Index 0 is hundredths-ones, 5 is minute-tens.
    digit_t [5:0] cnt;
    logic   [5:0] inc;
    logic   [5:0] carry;

    state_e       state_q, state_d;
    logic         lap_active_q, lap_active_d;
    logic         overflow_q, overflow_d;
    digit_t [5:0] snapshot_q, snapshot_d;

    logic tick_en, at_max, saturate, count_en, capture;

    assign tick_en  = (state_q == StRunning) && bus.tick_10ms;
    assign at_max   = (cnt[5] == MinTensMax) && (cnt[4] == DIGIT_MAX) &&
                      (cnt[3] == SEC_TENS_MAX) && (cnt[2] == DIGIT_MAX) &&
                      (cnt[1] == DIGIT_MAX) && (cnt[0] == DIGIT_MAX);
    assign saturate = tick_en && at_max && !WRAP_AT_MAX;
    assign count_en = tick_en && !saturate;

    assign inc = {carry[4:0], count_en};

    bcd_digit #(.Limit(DIGIT_MAX)) u_hund_ones (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[0]), .clr(bus.clear),
        .value(cnt[0]), .carry(carry[0])
    );
    bcd_digit #(.Limit(DIGIT_MAX)) u_hund_tens (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[1]), .clr(bus.clear),
        .value(cnt[1]), .carry(carry[1])
    );
    bcd_digit #(.Limit(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[2]), .clr(bus.clear),
        .value(cnt[2]), .carry(carry[2])
    );
    bcd_digit #(.Limit(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[3]), .clr(bus.clear),
        .value(cnt[3]), .carry(carry[3])
    );
    bcd_digit #(.Limit(DIGIT_MAX)) u_min_ones (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[4]), .clr(bus.clear),
        .value(cnt[4]), .carry(carry[4])
    );
    bcd_digit #(.Limit(MinTensMax)) u_min_tens (
        .clk(clk), .sync_reset(sync_reset), .inc(inc[5]), .clr(bus.clear),
        .value(cnt[5]), .carry(carry[5])
    );

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:    if (bus.start_stop) state_d = StRunning;
                StRunning: if (bus.start_stop || saturate) state_d = StPaused;
                // A saturated count cannot be resumed; only clear leaves it.
                StPaused:  if (bus.start_stop && !(at_max && !WRAP_AT_MAX)) state_d = StRunning;
                default:   state_d = StIdle;
            endcase
        end
    end

    assign capture = bus.lap && !lap_active_q && (state_q == StRunning);

    always_comb begin
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;
        snapshot_d   = snapshot_q;
        if (bus.clear) begin
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
            snapshot_d   = '0;
        end else begin
            if (carry[5] || saturate) overflow_d = 1'b1;
            if (capture) begin
                lap_active_d = 1'b1;
                snapshot_d   = cnt;
            end else if (bus.lap && lap_active_q && (state_q != StIdle)) begin
                lap_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q      <= StIdle;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
            snapshot_q   <= '0;
        end else begin
            state_q      <= state_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
            snapshot_q   <= snapshot_d;
        end
    end

    digit_t [5:0] disp;
    assign disp = lap_active_q ? snapshot_q : cnt;

    assign bus.timer_enabled  = (state_q == StRunning);
    assign bus.timer_clear    = (state_q == StIdle);
    assign bus.running        = (state_q == StRunning);
    assign bus.lap_active     = lap_active_q;
    assign bus.overflow       = overflow_q;
    assign bus.disp_hund_ones = disp[0];
    assign bus.disp_hund_tens = disp[1];
    assign bus.disp_sec_ones  = disp[2];
    assign bus.disp_sec_tens  = disp[3];
    assign bus.disp_min_ones  = disp[4];
    assign bus.disp_min_tens  = disp[5];

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: one wrapping instance and one saturating instance.
module tb_stopwatch_counter;

    logic clk = 1'b0;
    logic sync_reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stopwatch_counter_if bus_w ();
    stopwatch_counter_if bus_s ();

    stopwatch_counter #(.WRAP_AT_MAX(1'b1), .MAX_MIN_TENS(5)) dut_w (
        .clk(clk), .sync_reset(sync_reset), .bus(bus_w.slave)
    );
    stopwatch_counter #(.WRAP_AT_MAX(1'b0), .MAX_MIN_TENS(5)) dut_s (
        .clk(clk), .sync_reset(sync_reset), .bus(bus_s.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] disp_w();
        return {8'h0, bus_w.disp_min_tens, bus_w.disp_min_ones, bus_w.disp_sec_tens,
                bus_w.disp_sec_ones, bus_w.disp_hund_tens, bus_w.disp_hund_ones};
    endfunction

    function automatic logic [31:0] disp_s();
        return {8'h0, bus_s.disp_min_tens, bus_s.disp_min_ones, bus_s.disp_sec_tens,
                bus_s.disp_sec_ones, bus_s.disp_hund_tens, bus_s.disp_hund_ones};
    endfunction

    // Inputs are applied just after a falling edge and sampled on the next falling edge.
    task automatic cyc_w(input logic t, input logic ss, input logic lp, input logic cl);
        bus_w.tick_10ms = t; bus_w.start_stop = ss; bus_w.lap = lp; bus_w.clear = cl;
        @(negedge clk);
        bus_w.tick_10ms = 0; bus_w.start_stop = 0; bus_w.lap = 0; bus_w.clear = 0;
    endtask

    task automatic cyc_s(input logic t, input logic ss, input logic lp, input logic cl);
        bus_s.tick_10ms = t; bus_s.start_stop = ss; bus_s.lap = lp; bus_s.clear = cl;
        @(negedge clk);
        bus_s.tick_10ms = 0; bus_s.start_stop = 0; bus_s.lap = 0; bus_s.clear = 0;
    endtask

    task automatic ticks_w(input int n);
        for (int i = 0; i < n; i++) cyc_w(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic preload_w();
        force dut_w.u_min_tens.value_q  = 4'd5;
        force dut_w.u_min_ones.value_q  = 4'd9;
        force dut_w.u_sec_tens.value_q  = 4'd5;
        force dut_w.u_sec_ones.value_q  = 4'd9;
        force dut_w.u_hund_tens.value_q = 4'd9;
        force dut_w.u_hund_ones.value_q = 4'd9;
        #1;
        release dut_w.u_min_tens.value_q;
        release dut_w.u_min_ones.value_q;
        release dut_w.u_sec_tens.value_q;
        release dut_w.u_sec_ones.value_q;
        release dut_w.u_hund_tens.value_q;
        release dut_w.u_hund_ones.value_q;
    endtask

    task automatic preload_s();
        force dut_s.u_min_tens.value_q  = 4'd5;
        force dut_s.u_min_ones.value_q  = 4'd9;
        force dut_s.u_sec_tens.value_q  = 4'd5;
        force dut_s.u_sec_ones.value_q  = 4'd9;
        force dut_s.u_hund_tens.value_q = 4'd9;
        force dut_s.u_hund_ones.value_q = 4'd9;
        #1;
        release dut_s.u_min_tens.value_q;
        release dut_s.u_min_ones.value_q;
        release dut_s.u_sec_tens.value_q;
        release dut_s.u_sec_ones.value_q;
        release dut_s.u_hund_tens.value_q;
        release dut_s.u_hund_ones.value_q;
    endtask

    initial begin
        sync_reset = 1'b1;
        bus_w.tick_10ms = 0; bus_w.start_stop = 0; bus_w.lap = 0; bus_w.clear = 0;
        bus_s.tick_10ms = 0; bus_s.start_stop = 0; bus_s.lap = 0; bus_s.clear = 0;
        @(negedge clk);
        @(negedge clk);
        sync_reset = 1'b0;

        check("rst_disp", disp_w(), 32'h000000);
        check("rst_running", 32'(bus_w.running), 32'd0);
        check("rst_timer_clear", 32'(bus_w.timer_clear), 32'd1);
        check("rst_timer_en", 32'(bus_w.timer_enabled), 32'd0);
        check("rst_lap", 32'(bus_w.lap_active), 32'd0);
        check("rst_ovf", 32'(bus_w.overflow), 32'd0);

        // Start and count one second.
        cyc_w(1'b0, 1'b1, 1'b0, 1'b0);
        ticks_w(100);
        check("one_sec", disp_w(), 32'h000100);
        check("run_running", 32'(bus_w.running), 32'd1);
        check("run_timer_en", 32'(bus_w.timer_enabled), 32'd1);
        check("run_timer_clear", 32'(bus_w.timer_clear), 32'd0);

        ticks_w(5899);
        check("sec_59_99", disp_w(), 32'h005999);
        ticks_w(1);
        check("min_carry", disp_w(), 32'h010000);

        // Pause ignores ticks; the tick in the resume cycle is also ignored.
        cyc_w(1'b0, 1'b1, 1'b0, 1'b0);
        check("paused_running", 32'(bus_w.running), 32'd0);
        check("paused_timer_clear", 32'(bus_w.timer_clear), 32'd0);
        ticks_w(5);
        check("paused_hold", disp_w(), 32'h010000);
        cyc_w(1'b1, 1'b1, 1'b0, 1'b0);
        check("resume_tick_ignored", disp_w(), 32'h010000);
        check("resume_running", 32'(bus_w.running), 32'd1);
        ticks_w(1);
        check("resume_count", disp_w(), 32'h010001);

        // Wrap at maximum.
        preload_w();
        check("wrap_preload", disp_w(), 32'h595999);
        ticks_w(1);
        check("wrap_disp", disp_w(), 32'h000000);
        check("wrap_ovf", 32'(bus_w.overflow), 32'd1);
        check("wrap_running", 32'(bus_w.running), 32'd1);

        // Saturation at maximum.
        cyc_s(1'b0, 1'b1, 1'b0, 1'b0);
        preload_s();
        cyc_s(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat_disp", disp_s(), 32'h595999);
        check("sat_ovf", 32'(bus_s.overflow), 32'd1);
        check("sat_running", 32'(bus_s.running), 32'd0);
        cyc_s(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat_no_resume", 32'(bus_s.running), 32'd0);
        cyc_s(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_clear_disp", disp_s(), 32'h000000);
        check("sat_clear_ovf", 32'(bus_s.overflow), 32'd0);

        // Lap snapshot and release.
        cyc_w(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_ovf", 32'(bus_w.overflow), 32'd0);
        check("clr_timer_clear", 32'(bus_w.timer_clear), 32'd1);
        cyc_w(1'b0, 1'b1, 1'b0, 1'b0);
        ticks_w(1234);
        cyc_w(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_active", 32'(bus_w.lap_active), 32'd1);
        ticks_w(50);
        check("lap_frozen", disp_w(), 32'h001234);
        cyc_w(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_release", disp_w(), 32'h001284);
        check("lap_inactive", 32'(bus_w.lap_active), 32'd0);

        // Tick + pause together, then clear overriding everything.
        cyc_w(1'b0, 1'b0, 1'b0, 1'b1);
        cyc_w(1'b0, 1'b1, 1'b0, 1'b0);
        ticks_w(5);
        cyc_w(1'b1, 1'b1, 1'b0, 1'b0);
        check("tick_pause_disp", disp_w(), 32'h000006);
        check("tick_pause_running", 32'(bus_w.running), 32'd0);
        cyc_w(1'b1, 1'b1, 1'b0, 1'b1);
        check("clear_all_disp", disp_w(), 32'h000000);
        check("clear_all_timer_clear", 32'(bus_w.timer_clear), 32'd1);
        check("clear_all_running", 32'(bus_w.running), 32'd0);

        // Synchronous reset mid-run with a lap frozen.
        cyc_w(1'b0, 1'b1, 1'b0, 1'b0);
        ticks_w(20107);
        cyc_w(1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_disp", disp_w(), 32'h032107);
        #1 sync_reset = 1'b1;
        #2 sync_reset = 1'b0;
        @(negedge clk);
        check("glitch_lap", 32'(bus_w.lap_active), 32'd1);
        check("glitch_running", 32'(bus_w.running), 32'd1);
        sync_reset = 1'b1;
        cyc_w(1'b1, 1'b0, 1'b0, 1'b0);
        sync_reset = 1'b0;
        check("reset_disp", disp_w(), 32'h000000);
        check("reset_lap", 32'(bus_w.lap_active), 32'd0);
        check("reset_running", 32'(bus_w.running), 32'd0);
        check("reset_timer_clear", 32'(bus_w.timer_clear), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Consumes the single-cycle elapsed_10ms pulse from the tick timer and keeps the elapsed time as six BCD digits, MM:SS.hh.
- Owns the run/pause/idle control FSM and drives the timer's enable and clear inputs.
- Feeds the display multiplexer with either the live time or a frozen lap snapshot.

Parameters:
- WRAP_AT_MAX, 1: 1 = after 59:59.99 the next tick wraps to 00:00.00 and sets overflow. 0 = hold 59:59.99, set overflow, go to PAUSED.
- MAX_MIN_TENS, 5: highest minute-tens digit before wrap/saturation (legal 1..9).

Ports:
- clk  in  1  system clock (50 MHz)
- sync_reset  in  1  synchronous reset, active-high
- tick_10ms  in  1  one-cycle pulse from timer elapsed_10ms
- start_stop  in  1  one-cycle debounced pulse: start/pause/resume
- lap  in  1  one-cycle debounced pulse: freeze/release display
- clear  in  1  one-cycle debounced pulse: return to zero
- timer_enabled  out  1  drives timer.enabled
- timer_clear  out  1  drives timer.clear
- running  out  1  state == RUNNING
- lap_active  out  1  display frozen
- overflow  out  1  sticky; set on wrap/saturation
- disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones, disp_hund_tens, disp_hund_ones  out  4 each  BCD display digits

Behaviour:
- All state updates on the rising edge of clk. sync_reset sampled on that edge only; it has priority over every other input.
- Reset: state = IDLE; all count and snapshot digits = 0; lap_active = 0; overflow = 0.
- FSM states:
  - IDLE: count zero.
  - RUNNING.
  - PAUSED.
- FSM transitions on start_stop:
  - IDLE -> RUNNING.
  - RUNNING -> PAUSED.
  - PAUSED -> RUNNING.
- clear in any state:
  - next state = IDLE; count = 0; snapshot = 0; lap_active = 0; overflow = 0.
  - clear overrides start_stop, lap and tick in the same cycle.
- Counting:
  - tick_10ms is counted only when the registered state is RUNNING, including the cycle in which start_stop pauses. A tick in the cycle start_stop leaves IDLE/PAUSED is ignored.
  - 1-cycle latency: the digit update is visible the cycle after the tick.
  - Cascade: hund_ones 0..9 -> hund_tens 0..9 -> sec_ones 0..9 -> sec_tens 0..5 -> min_ones 0..9 -> min_tens 0..MAX_MIN_TENS. Each carry is combinational within the same cycle.
  - Max-value tick, WRAP_AT_MAX=1: all digits go to 0, overflow goes to 1, state stays RUNNING.
  - Max-value tick, WRAP_AT_MAX=0: digits hold, overflow goes to 1, state goes to PAUSED. start_stop in PAUSED while at max keeps the state PAUSED.
- Timer control, combinational from the registered state:
  - timer_enabled = (state == RUNNING).
  - timer_clear = (state == IDLE). This realigns timer phase to zero before every fresh start. Pause does not clear the timer; the sub-10 ms phase is retained.
- Lap:
  - lap while RUNNING and lap_active=0: snapshot <= current count (pre-increment if a tick arrives in the same cycle); lap_active <= 1.
  - lap while lap_active=1, any non-IDLE state: lap_active <= 0.
  - lap in IDLE: ignored. lap while PAUSED with lap_active=0: ignored.
- Display: disp_* = lap_active ? snapshot : count. Pure mux, no extra latency.
- Simultaneous start_stop and lap in RUNNING: both take effect (pause + snapshot).
- Digits never hold a non-BCD value. No illegal state is reachable; the FSM default branch returns to IDLE.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state encoding IDLE = 2'd0, RUNNING = 2'd1, PAUSED = 2'd2;
  - digit limit constants DIGIT_MAX = 4'd9, SEC_TENS_MAX = 4'd5;
  - BCD digit width 4.
- Sub-module bcd_digit: one BCD digit with inputs inc, clr and a parameterised limit; outputs value and carry (= inc and value == limit). Instantiate six of them, chained through carry.

Test Plan:
- Reset, then start_stop, then 100 tick_10ms pulses -> digits 00:01.00; running = 1; timer_enabled = 1; timer_clear = 0.
- Run to 00:59.99, one tick -> 01:00.00. Pause, apply 5 ticks -> unchanged; resume, 1 tick -> 01:00.01.
- Preload to 59:59.99 with WRAP_AT_MAX=1, one tick -> 00:00.00, overflow = 1, running = 1. With WRAP_AT_MAX=0 -> stays 59:59.99, overflow = 1, running = 0.
- Lap at 00:12.34 and keep running 50 ticks -> display 00:12.34 while the internal count reaches 00:12.84. Second lap -> display 00:12.84.
- Tick and start_stop together in RUNNING at 00:00.05 -> 00:00.06 and PAUSED. clear together with tick and start_stop -> IDLE, all zeros, timer_clear = 1.
- sync_reset asserted mid-run at 03:21.07 with lap_active = 1 -> next cycle: all digits 0, lap_active = 0, IDLE. sync_reset pulse between clock edges without an edge -> no effect.
